// File: rtl/window_builder.sv
// window_builder: builds a 3x3 RGB neighbourhood for every interior pixel of a
// raster-ordered IMG_W x IMG_H frame. Two line buffers hold the previous two
// rows; a 3x3 shift register forms the window; one output register with
// valid/ready handshake feeds the intensity stage.
module window_builder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [23:0]  pix_in,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic         win_ready,
  output logic [215:0] pixelData,
  output logic         win_valid,
  output logic         frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Raster position of the next pixel to be accepted
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // lb0 holds the row directly above, lb1 the row two above
  logic [23:0] lb0_q [IMG_W];
  logic [23:0] lb0_d [IMG_W];
  logic [23:0] lb1_q [IMG_W];
  logic [23:0] lb1_d [IMG_W];

  // Window pixel k = 3*row + col, row 0 at top, col 0 at left
  logic [23:0] win_q [9];
  logic [23:0] win_d [9];

  logic [215:0] pix_data_q, pix_data_d;
  logic         win_valid_q, win_valid_d;
  logic         frame_done_q, frame_done_d;

  logic accept_s;
  logic emit_s;
  logic last_col_s;
  logic last_row_s;

  // Input handshake: accept whenever the output register is empty or draining
  always_comb begin
    pix_ready  = !win_valid_q || win_ready;
    accept_s   = pix_valid && pix_ready;
    last_col_s = (col_q == COL_LAST);
    last_row_s = (row_q == ROW_LAST);
    emit_s     = accept_s && (col_q >= COL_TWO) && (row_q >= ROW_TWO);
  end

  // Raster counters and end-of-frame pulse
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    if (accept_s) begin
      if (last_col_s) begin
        col_d = {CW{1'b0}};
        if (last_row_s) begin
          row_d        = {RW{1'b0}};
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // Window shift and line buffer rotation at the current column
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      win_d[k] = win_q[k];
    end
    for (int i = 0; i < IMG_W; i++) begin
      lb0_d[i] = lb0_q[i];
      lb1_d[i] = lb1_q[i];
    end
    if (accept_s) begin
      for (int c = 0; c < 2; c++) begin
        win_d[c]     = win_q[c + 1];
        win_d[3 + c] = win_q[4 + c];
        win_d[6 + c] = win_q[7 + c];
      end
      win_d[2]     = lb1_q[col_q];
      win_d[5]     = lb0_q[col_q];
      win_d[8]     = pix_in;
      lb1_d[col_q] = lb0_q[col_q];
      lb0_d[col_q] = pix_in;
    end else begin
      win_d[8] = win_q[8];
    end
  end

  // Output register: load on emit, clear on drain, hold while stalled
  always_comb begin
    pix_data_d  = pix_data_q;
    win_valid_d = win_valid_q;
    if (emit_s) begin
      for (int k = 0; k < 9; k++) begin
        pix_data_d[215 - 24*k -: 24] = win_d[k];
      end
      win_valid_d = 1'b1;
    end else if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
    end
  end

  // Control, window and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      pix_data_q   <= 216'd0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= 24'd0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pix_data_q   <= pix_data_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  // Line buffer storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < IMG_W; i++) begin
      lb0_q[i] <= lb0_d[i];
      lb1_q[i] <= lb1_d[i];
    end
  end

  // Registered outputs
  always_comb begin
    pixelData  = pix_data_q;
    win_valid  = win_valid_q;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_window_builder.sv
// Directed bench for window_builder on a 4x4 frame with a window scoreboard.
module tb_window_builder;

  localparam int W = 4;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [23:0]  pix_in;
  logic         pix_valid;
  logic         pix_ready;
  logic         win_ready;
  logic [215:0] pixelData;
  logic         win_valid;
  logic         frame_done;

  window_builder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_ready  (win_ready),
    .pixelData  (pixelData),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [215:0] exp_q [$];
  int total = 0;
  int bad   = 0;
  int got   = 0;
  int fd_cnt = 0;
  logic bp_arm = 1'b0;

  function automatic logic [23:0] pix(input int n);
    int a;
    int b;
    a = n + 64;
    b = n + 128;
    return {n[7:0], a[7:0], b[7:0]};
  endfunction

  // Expected window for an accept at (x,y), centred on (x-1,y-1)
  function automatic logic [215:0] win_of(input int x, input int y);
    logic [215:0] w;
    w = 216'd0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[215 - 24*(3*r + c) -: 24] = pix((y - 2 + r) * W + (x - 2 + c));
      end
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: compare each window at the edge where it is handed over
  always @(negedge clk) begin
    if (!rst && frame_done) fd_cnt++;
    if (!rst && win_valid && win_ready) begin
      chk("window_expected", 216'(exp_q.size() != 0), 216'd1);
      if (exp_q.size() != 0) begin
        chk("window", pixelData, exp_q.pop_front());
        got++;
      end
    end
  end

  // Backpressure: hold win_ready low for 5 cycles after the first window when armed
  initial begin
    logic [215:0] held;
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_arm && win_valid) begin
        bp_arm = 1'b0;
        win_ready = 1'b0;
        held = pixelData;
        repeat (5) begin
          @(negedge clk);
          chk("stall_ready", 216'(pix_ready), 216'd0);
          chk("stall_data", pixelData, held);
          chk("stall_valid", 216'(win_valid), 216'd1);
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
      end
    end
  end

  task automatic send(input int n, input int idle);
    int x;
    int y;
    int cyc;
    logic acc;
    bit emit;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
    x = n % W;
    y = n / W;
    emit = (x >= 2) && (y >= 2);
    pix_in = pix(n);
    pix_valid = 1'b1;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    pix_valid = 1'b0;
    chk("accept_timeout", 216'(acc), 216'd1);
    if (emit) exp_q.push_back(win_of(x, y));
    chk("win_valid_after_accept", 216'(win_valid), 216'(emit));
    chk("frame_done", 216'(frame_done), 216'(n == W*H - 1));
  endtask

  task automatic drain(input int want);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || win_valid) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain_timeout", 216'(cyc < 100), 216'd1);
    chk("window_count", 216'(got), 216'(want));
    chk("frame_done_clear", 216'(frame_done), 216'd0);
    got = 0;
  endtask

  task automatic reset_checks();
    chk("rst_win_valid", 216'(win_valid), 216'd0);
    chk("rst_pixelData", pixelData, 216'd0);
    chk("rst_frame_done", 216'(frame_done), 216'd0);
    chk("rst_pix_ready", 216'(pix_ready), 216'd1);
  endtask

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_in = 24'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_checks();

    // T1 basic stream with fixed first-window corner checks
    for (int n = 0; n < 16; n++) begin
      send(n, 0);
      if (n == 10) begin
        chk("first_top_left", 216'(pixelData[215:192]), 216'(24'h004080));
        chk("first_bot_right", 216'(pixelData[23:0]), 216'(24'h0A4A8A));
      end
    end
    drain(4);

    // T2 backpressure after the first window
    bp_arm = 1'b1;
    for (int n = 0; n < 16; n++) send(n, 0);
    drain(4);
    chk("bp_consumed", 216'(bp_arm), 216'd0);

    // T3 two back-to-back frames
    fd_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < 16; n++) send(n, 0);
    end
    drain(8);
    chk("frame_done_pulses", 216'(fd_cnt), 216'd2);

    // T4 reset after 11 pixels discards the pending window
    for (int n = 0; n < 11; n++) send(n, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    got = 0;
    reset_checks();
    for (int n = 0; n < 16; n++) send(n, 0);
    drain(4);

    // T5 random idle gaps between pixels
    for (int n = 0; n < 16; n++) send(n, int'($urandom_range(0, 3)));
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
